// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM encoding and the {pc, instr} queue entry.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FETCH,
        FS_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with flush; the head is read straight from
// the storage registers.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_pop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];
    assign do_pop = pop && !empty;

    // The caller only raises push when there is room (or a pop frees a slot).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch: owns the PC, drives the instruction-memory address and
// queues {pc, instr} pairs towards IF/ID; handles redirect flushes and end-of-memory halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_adr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic         at_end;
    logic         pop_fire;
    logic         push_fire;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_wr;

    assign imem_adr  = pc;
    assign out_valid = !q_empty;
    assign out_pc    = q_head.pc;
    assign out_instr = q_head.instr;

    // 65-bit compare so a PC near 2^64 cannot wrap past the end-of-memory test.
    assign at_end    = ({1'b0, pc} + 65'(INSTR_BYTES - 1)) >= 65'(MEM_BYTES);
    assign pop_fire  = out_valid && out_ready;
    assign push_fire = (state == FS_FETCH) && !redirect && !at_end
                       && (!q_full || pop_fire);
    assign q_wr      = '{pc: pc, instr: imem_instr};

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_fire),
        .pop     (out_ready),
        .flush   (redirect),
        .wr_entry(q_wr),
        .full    (q_full),
        .empty   (q_empty),
        .head    (q_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FS_IDLE;
            pc           <= RESET_PC;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else if (redirect) begin
            state  <= FS_FETCH;
            pc     <= {redirect_pc[63:2], 2'b00};
            halted <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            case (state)
                FS_IDLE: state <= FS_FETCH;
                FS_FETCH: begin
                    if (at_end) begin
                        state  <= FS_HALT;
                        halted <= 1'b1;
                    end else if (push_fire) begin
                        pc          <= pc + 64'(INSTR_BYTES);
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                FS_HALT: state <= FS_HALT;
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 16-byte instruction memory.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_adr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [16];
    logic [31:0] exp_instr [4];

    always #5 clk = ~clk;

    always_comb begin
        imem_instr = '0;
        if (imem_adr < 64'd13) begin
            imem_instr = {mem[imem_adr[3:0] + 4'd3], mem[imem_adr[3:0] + 4'd2],
                          mem[imem_adr[3:0] + 4'd1], mem[imem_adr[3:0]]};
        end
    end

    fetch_sequencer #(
        .RESET_PC (64'h0),
        .MEM_BYTES(16),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_adr    (imem_adr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .halted      (halted),
        .misalign_err(misalign_err),
        .fetch_count (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = ready;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", out_instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_err); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fetch_count); end
        checks++; if (imem_adr !== 64'h0) begin errors++; $display("FAIL rst_adr: got %h expected 0", imem_adr); end
        reset_n = 1'b1;
    endtask

    // Reset already released with out_ready=1: stream 0..12, then halt at 16.
    task automatic test_stream();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid: got %b expected 0", out_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_pc !== 64'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, 64'(4 * i)); end
            checks++; if (out_instr !== exp_instr[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, out_instr, exp_instr[i]); end
            tick();
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stream_count: got %0d expected 4", fetch_count); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stream_halted: got %b expected 1", halted); end
        checks++; if (imem_adr !== 64'd16) begin errors++; $display("FAIL stream_halt_adr: got %h expected 16", imem_adr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_halt_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL stream_halt_hold: got valid=%b halted=%b expected valid=0 halted=1", out_valid, halted); end
    endtask

    task automatic test_halt_redirect();
        redirect    = 1'b1;
        redirect_pc = 64'd4;
        tick();
        redirect = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hr_halted: got %b expected 0", halted); end
        checks++; if (imem_adr !== 64'd4) begin errors++; $display("FAIL hr_adr: got %h expected 4", imem_adr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hr_valid: got %b expected 0", out_valid); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * i)) begin errors++; $display("FAIL hr_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, 64'(4 * i)); end
        end
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hr_rehalt: got halted=%b valid=%b expected 1/0", halted, out_valid); end
        checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL hr_count: got %0d expected 7", fetch_count); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 64'h0 || out_instr !== exp_instr[0]) begin errors++; $display("FAIL bp_head: got pc=%h instr=%h expected 0/%h", out_pc, out_instr, exp_instr[0]); end
        checks++; if (imem_adr !== 64'd8) begin errors++; $display("FAIL bp_adr: got %h expected 8", imem_adr); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", fetch_count); end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== exp_instr[i]) begin errors++; $display("FAIL bp_drain[%0d]: got valid=%b pc=%h instr=%h expected pc=%h instr=%h", i, out_valid, out_pc, out_instr, 64'(4 * i), exp_instr[i]); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL bp_count_end: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || imem_adr !== 64'd8) begin errors++; $display("FAIL rf_pre: got valid=%b pc=%h adr=%h expected 1/0/8", out_valid, out_pc, imem_adr); end
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'd8;
        tick();
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_flush: got %b expected 0", out_valid); end
        checks++; if (imem_adr !== 64'd8) begin errors++; $display("FAIL rf_adr: got %h expected 8", imem_adr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'd8 || out_instr !== 32'h8B040086) begin errors++; $display("FAIL rf_first: got valid=%b pc=%h instr=%h expected 1/8/8b040086", out_valid, out_pc, out_instr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'd12) begin errors++; $display("FAIL rf_second: got valid=%b pc=%h expected 1/12", out_valid, out_pc); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL rf_count: got %0d expected 4", fetch_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_misalign();
        redirect    = 1'b1;
        redirect_pc = 64'h6;
        tick();
        redirect = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL ma_set: got %b expected 1", misalign_err); end
        checks++; if (imem_adr !== 64'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL ma_adr: got adr=%h valid=%b expected 4/0", imem_adr, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'd4 || out_instr !== 32'hF84000A4) begin errors++; $display("FAIL ma_first: got valid=%b pc=%h instr=%h expected 1/4/f84000a4", out_valid, out_pc, out_instr); end
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL ma_sticky: got %b expected 1", misalign_err); end
        checks++; if (imem_adr !== 64'd0) begin errors++; $display("FAIL ma_realign_adr: got %h expected 0", imem_adr); end
    endtask

    task automatic test_async_reset();
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0) begin errors++; $display("FAIL ar_pre: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
        checks++; if (imem_adr !== 64'd0) begin errors++; $display("FAIL ar_adr: got %h expected 0", imem_adr); end
        checks++; if (misalign_err !== 1'b0 || fetch_count !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL ar_state: got misalign=%b count=%0d halted=%b expected 0/0/0", misalign_err, fetch_count, halted); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_idle: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instr !== exp_instr[0]) begin errors++; $display("FAIL ar_restart0: got valid=%b pc=%h instr=%h expected 1/0/%h", out_valid, out_pc, out_instr, exp_instr[0]); end
        tick();
        checks++; if (out_pc !== 64'd4 || out_instr !== exp_instr[1]) begin errors++; $display("FAIL ar_restart1: got pc=%h instr=%h expected 4/%h", out_pc, out_instr, exp_instr[1]); end
    endtask

    initial begin
        exp_instr[0] = 32'h8B1F03E5;
        exp_instr[1] = 32'hF84000A4;
        exp_instr[2] = 32'h8B040086;
        exp_instr[3] = 32'hF80010A6;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) begin
                mem[4 * i + b] = exp_instr[i][8 * b +: 8];
            end
        end

        test_reset();
        test_stream();
        test_halt_redirect();
        test_backpressure();
        test_redirect_full();
        test_misalign();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
